// File: rtl/alu_iter.sv
// Iterative execute-stage ALU: logic/arithmetic ops finish in one cycle, shifts step one bit per cycle.
// Handshake: start_i is accepted only while idle (busy_o low); done_o pulses for one cycle with result_o valid.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [4:0] OP_NOTH = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADDU = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_NAND = 5'd8;
    localparam logic [4:0] OP_SMAL = 5'd9;
    localparam logic [4:0] OP_LEFT = 5'd10;
    localparam logic [4:0] OP_RIGH = 5'd11;
    localparam logic [4:0] OP_RS   = 5'd12;
    localparam logic [4:0] OP_EQUA = 5'd13;
    localparam logic [4:0] OP_NEQU = 5'd14;
    localparam logic [4:0] OP_BIG  = 5'd15;
    localparam logic [4:0] OP_JTYP = 5'd16;
    localparam logic [4:0] OP_LUI  = 5'd17;
    localparam logic [4:0] OP_SRA  = 5'd18;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_A = 2'd2;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum, diff, alu_res, acc_step;
    logic             add_ovf, sub_ovf, alu_ovf, is_shift, slt, sgt;
    logic [1:0]       dir_new;

    always_comb begin
        sum      = src1_i + src2_i;
        diff     = src1_i - src2_i;
        add_ovf  = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
        sub_ovf  = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
        slt      = $signed(src1_i) < $signed(src2_i);
        sgt      = $signed(src1_i) > $signed(src2_i);
        is_shift = (ctrl_i == OP_LEFT) || (ctrl_i == OP_RIGH) || (ctrl_i == OP_SRA);
        alu_ovf  = 1'b0;
        case (ctrl_i)
            OP_NOTH: alu_res = '0;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_XOR:  alu_res = src1_i ^ src2_i;
            OP_NOR:  alu_res = ~(src1_i | src2_i);
            OP_NAND: alu_res = ~(src1_i & src2_i);
            OP_SMAL: alu_res = {{(WIDTH-1){1'b0}}, slt};
            // A zero-length shift completes here; non-zero shifts go through SHIFT.
            OP_LEFT, OP_RIGH, OP_SRA: alu_res = src2_i;
            OP_RS:   alu_res = src1_i;
            OP_EQUA, OP_NEQU: alu_res = diff;
            OP_BIG:  alu_res = {{(WIDTH-1){1'b0}}, sgt};
            OP_JTYP: alu_res = '0;
            OP_LUI:  alu_res = {src2_i[15:0], {(WIDTH-16){1'b0}}};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (ctrl_i)
            OP_LEFT: dir_new = DIR_L;
            OP_RIGH: dir_new = DIR_R;
            default: dir_new = DIR_A;
        endcase
        case (dir_q)
            DIR_L:   acc_step = {acc_q[WIDTH-2:0], 1'b0};
            DIR_R:   acc_step = {1'b0, acc_q[WIDTH-1:1]};
            DIR_A:   acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (is_shift && (shamt_i != '0)) begin
                        acc_d   = src2_i;
                        cnt_d   = shamt_i;
                        dir_d   = dir_new;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_step;
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_L;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign result_o   = result_q;
    assign zero_o     = (result_q == '0);
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q == S_SHIFT);
    assign done_o     = done_q;

endmodule

// File: doc/alu_iter.md
# alu_iter

Iterative execute-stage ALU that consumes the 5-bit ALU control code, the operands and the shift amount produced by the decode/ALU-control path. Logic and arithmetic operations complete in one cycle. Shifts (SLL, SRL, SRA) run one bit per cycle under a start/done handshake, so no 32-bit barrel shifter is needed. The block sits directly downstream of ALU control and feeds writeback and branch-compare logic.

## Interface
- WIDTH, 32: operand and result width.
- SHW, 5: shift-amount width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-low.
- start_i  in  1  launch request; sampled only while IDLE.
- ctrl_i  in  5  ALU control code.
- src1_i  in  WIDTH  rs operand.
- src2_i  in  WIDTH  rt operand.
- shamt_i  in  SHW  shift amount.
- result_o  out  WIDTH  registered result; held until the next completion.
- zero_o  out  1  combinational, result_o == 0.
- overflow_o  out  1  registered signed-overflow flag (ADD/SUB only, else 0).
- busy_o  out  1  high while in SHIFT.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Opcodes, result when start_i is accepted in IDLE:
  - 0 NOTH: 0.
  - 1 ADD: src1+src2, overflow_o set on signed overflow.
  - 2 ADDU: src1+src2, overflow_o=0.
  - 3 SUB: src1−src2, overflow_o set on signed overflow.
  - 4 AND, 5 OR, 6 XOR, 7 NOR, 8 NAND: bitwise.
  - 9 SMAL: (signed src1 < signed src2) ? 1 : 0.
  - 10 LEFT (SLL), 11 RIGH (SRL), 18 SRA: src2 shifted by shamt_i; SRA replicates bit 31.
  - 12 RS: src1.
  - 13 EQUA, 14 NEQU: src1−src2, overflow_o=0; branch logic uses zero_o.
  - 15 BIG: (signed src1 > signed src2) ? 1 : 0.
  - 16 JTYP: 0.
  - 17 LUI: {src2[15:0], 16'h0}.
  - 19–31: result 0, overflow 0.
- Two-state FSM, IDLE and SHIFT.
- IDLE, start_i=1, non-shift op or shamt_i=0:
  - result_o and overflow_o are written at that edge; done_o=1 next cycle; stay IDLE.
  - shamt_i=0 returns src2 unchanged.
- IDLE, start_i=1, shift op with shamt_i=N>0:
  - acc←src2, cnt←N, the op is latched; go to SHIFT. result_o is not updated yet.
- SHIFT, each edge:
  - acc shifts 1 bit in the latched direction (SRA fill = acc[31]); cnt decrements.
  - On the edge where cnt==1: result_o←shifted acc, overflow_o←0, done_o=1 next cycle, go to IDLE.
- start_i in SHIFT is ignored; no queueing.
- Operand inputs are don't-care after acceptance.
- done_o is high only in the cycle after completion. Since the FSM is IDLE that cycle, a new start_i is accepted there (back-to-back issue).
- Reset values: result_o=0, overflow_o=0, busy_o=0, done_o=0, zero_o=1, state IDLE, cnt=0.
- Reset mid-SHIFT aborts the operation immediately; no done_o is produced.

## Timing
- Cycle 0 is the cycle in which start_i is accepted.
- Non-shift op or shamt=0: done_o and result valid in cycle 1; busy_o never asserts.
- Shift with N>0:
  - busy_o high in cycles 1..N.
  - done_o and result valid in cycle N+1; busy_o low in cycle N+1.
- Maximum latency is 32 cycles (N=31).
- zero_o follows result_o combinationally, with no extra latency.
- Outputs change only on clk_i edges or on rst_i assertion.

## Test plan
- ADD, src1=0x7FFFFFFF, src2=1 -> cycle 1: result_o=0x80000000, overflow_o=1, zero_o=0, done_o=1 for exactly one cycle.
- SRA, src2=0x80000000, shamt=4 -> busy_o cycles 1–4; cycle 5: result_o=0xF8000000, done_o=1. SRL with the same inputs -> 0x08000000.
- SLL, src2=1, shamt=31, with start_i re-pulsed with ADD in cycle 10 -> ADD ignored; cycle 32: result_o=0x80000000. An ADD started in cycle 32 completes in cycle 33.
- Directed single-cycle checks:
  - SMAL, src1=0xFFFFFFFF, src2=1 -> 1.
  - BIG, same operands -> 0.
  - LUI, src2=0x00001234 -> 0x12340000.
  - EQUA, src1=src2=5 -> zero_o=1.
  - Code 19 -> 0.
- SRL with shamt=8: assert rst_i low in cycle 3, release in cycle 5 -> all outputs at reset values, no done_o. A following ADD 2+3 -> 5 in cycle 1 after its start.
- Shift with shamt=0, src2=0xDEADBEEF -> cycle 1: result 0xDEADBEEF, busy_o never high.
